// File: rtl/cordic_engine.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_engine
//  Purpose  : Iterative CORDIC core. Full-circle angle range by quadrant
//             pre-fold, runtime rotation/vectoring mode, valid/ready on both
//             sides with output backpressure. One operation in flight.
//  Option   : CORDIC_GAIN_COMP_EN adds a GAIN state that removes the CORDIC
//             gain K from x/y before the result is presented.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module cordic_engine #(
   parameter int XY_BITS    = 16,
   parameter int THETA_BITS = 16,
   parameter int ANG_FRAC   = 8,
   parameter int ITERATIONS = 16,
   parameter int GUARD_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode_i,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [XY_BITS:0]      x_i,
   input  logic [XY_BITS:0]      y_i,
   input  logic [THETA_BITS:0]   theta_i,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [XY_BITS:0]      x_o,
   output logic [XY_BITS:0]      y_o,
   output logic [THETA_BITS:0]   theta_o
);

   localparam int c_XW = XY_BITS + 1 + GUARD_BITS;
   localparam int c_TW = THETA_BITS + 2;
   localparam int c_CW = $clog2(ITERATIONS);

   localparam logic signed [c_TW-1:0] c_DEG90  = c_TW'(90 << ANG_FRAC);
   localparam logic signed [c_TW-1:0] c_DEG180 = c_TW'(180 << ANG_FRAC);
   localparam logic [c_CW-1:0]        c_LAST   = c_CW'(ITERATIONS - 1);

   // Symmetric x/y output limits: +/-(2^XY_BITS - 1)
   localparam logic signed [c_XW-1:0] c_XMAX = c_XW'((64'd1 << XY_BITS) - 64'd1);
   localparam logic signed [c_XW-1:0] c_XMIN = -c_XMAX;

   // round(atan(2^-idx) in degrees * 2^ANG_FRAC). atan is a Taylor series in
   // 2^-36 fixed point (x is a power of two, so every power is a shift), then
   // scaled by 180/pi held as 2^20 fixed point (60078979).
   function automatic logic signed [c_TW-1:0] atanVal(input int idx);
      logic [63:0] acc;
      logic [63:0] term;
      logic [63:0] deg;
      int          sh;
      acc = '0;
      for (int k = 0; k < 32; k++) begin
         sh = idx * (2 * k + 1);
         if (sh <= 36) begin
            term = (64'd1 << (36 - sh)) / 64'(2 * k + 1);
            if (k % 2 == 0) acc = acc + term;
            else            acc = acc - term;
         end
      end
      deg = acc * 64'd60078979;
      deg = (deg + (64'd1 << (55 - ANG_FRAC))) >> (56 - ANG_FRAC);
      if (idx == 0) return c_TW'(45 << ANG_FRAC);
      return c_TW'(deg);
   endfunction

   function automatic logic [XY_BITS:0] satXY(input logic signed [c_XW-1:0] v);
      if (v > c_XMAX) return c_XMAX[XY_BITS:0];
      if (v < c_XMIN) return c_XMIN[XY_BITS:0];
      return v[XY_BITS:0];
   endfunction

   // Internal theta carries one extra bit; clamp when it is not a sign copy.
   function automatic logic [THETA_BITS:0] satTh(input logic signed [c_TW-1:0] v);
      if (v[c_TW-1] != v[c_TW-2])
         return v[c_TW-1] ? {1'b1, {THETA_BITS{1'b0}}} : {1'b0, {THETA_BITS{1'b1}}};
      return v[THETA_BITS:0];
   endfunction

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_GAIN = 2'd2,
      S_DONE = 2'd3
   } stateT;

   stateT                   r_state;
   stateT                   w_stateNext;
   logic signed [c_XW-1:0]  r_x;
   logic signed [c_XW-1:0]  r_y;
   logic signed [c_TW-1:0]  r_theta;
   logic                    r_mode;
   logic [c_CW-1:0]         r_cnt;
   logic [XY_BITS:0]        r_xOut;
   logic [XY_BITS:0]        r_yOut;
   logic [THETA_BITS:0]     r_thOut;

   logic signed [c_XW-1:0]  w_xIn, w_yIn, w_xFold, w_yFold;
   logic signed [c_TW-1:0]  w_thIn, w_thFold;
   logic signed [c_XW-1:0]  w_xSh, w_ySh, w_xNext, w_yNext;
   logic signed [c_TW-1:0]  w_thNext;
   logic                    w_dPos;
   logic                    w_last;
   logic signed [c_TW-1:0]  w_atanTab [ITERATIONS];

   for (genvar gi = 0; gi < ITERATIONS; gi++) begin : g_atan
      assign w_atanTab[gi] = atanVal(gi);
   end

   assign w_last = (r_cnt == c_LAST);

`ifdef CORDIC_GAIN_COMP_EN
   // round(2^(XY_BITS-1)/K): K^2 is accumulated as a product of (1+2^-2i)
   // in 2^20 fixed point, then an integer square root of 4*g^2 gives 2g.
   function automatic logic [XY_BITS:0] gainVal();
      logic [63:0] p;
      logic [63:0] num;
      logic [63:0] res;
      logic [63:0] bitv;
      p = 64'd1 << 20;
      for (int i = 0; i < ITERATIONS; i++) p = p + (p >> (2 * i));
      num  = (64'd1 << (2 * XY_BITS + 20)) / p;
      res  = '0;
      bitv = 64'd1 << 62;
      for (int j = 0; j < 32; j++) begin
         if (num >= res + bitv) begin
            num = num - (res + bitv);
            res = (res >> 1) + bitv;
         end else begin
            res = res >> 1;
         end
         bitv = bitv >> 2;
      end
      return (XY_BITS + 1)'((res + 64'd1) >> 1);
   endfunction

   localparam int c_PW = c_XW + XY_BITS + 2;
   localparam logic signed [c_PW-1:0] c_GAIN = c_PW'({1'b0, gainVal()});
   localparam logic signed [c_PW-1:0] c_HALF = c_PW'(64'd1 << (XY_BITS - 2));

   logic signed [c_PW-1:0] w_xRnd, w_yRnd;
   logic signed [c_XW-1:0] w_xGain, w_yGain;

   // Gain removal: multiply by 1/K in Q(XY_BITS-1), round half up, drop fraction
   always_comb begin
      w_xRnd  = c_PW'(r_x) * c_GAIN + c_HALF;
      w_yRnd  = c_PW'(r_y) * c_GAIN + c_HALF;
      w_xGain = w_xRnd[XY_BITS-1 +: c_XW];
      w_yGain = w_yRnd[XY_BITS-1 +: c_XW];
   end
`endif

   // Operand pre-fold into the +/-90 degree convergence range
   always_comb begin
      w_xIn    = c_XW'($signed(x_i));
      w_yIn    = c_XW'($signed(y_i));
      w_thIn   = c_TW'($signed(theta_i));
      w_xFold  = w_xIn;
      w_yFold  = w_yIn;
      w_thFold = w_thIn;
      if (mode_i) begin
         if (w_xIn[c_XW-1]) begin
            w_xFold  = -w_xIn;
            w_yFold  = -w_yIn;
            w_thFold = y_i[XY_BITS] ? -c_DEG180 : c_DEG180;
         end
      end else if (w_thIn > c_DEG90) begin
         w_xFold  = -w_xIn;
         w_yFold  = -w_yIn;
         w_thFold = w_thIn - c_DEG180;
      end else if (w_thIn < -c_DEG90) begin
         w_xFold  = -w_xIn;
         w_yFold  = -w_yIn;
         w_thFold = w_thIn + c_DEG180;
      end
   end

   // One micro-rotation at index r_cnt; zero counts as positive for direction
   always_comb begin
      w_xSh  = r_x >>> r_cnt;
      w_ySh  = r_y >>> r_cnt;
      w_dPos = r_mode ? r_y[c_XW-1] : ~r_theta[c_TW-1];
      if (w_dPos) begin
         w_xNext  = r_x - w_ySh;
         w_yNext  = r_y + w_xSh;
         w_thNext = r_theta - w_atanTab[r_cnt];
      end else begin
         w_xNext  = r_x + w_ySh;
         w_yNext  = r_y - w_xSh;
         w_thNext = r_theta + w_atanTab[r_cnt];
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_stateNext;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_stateNext = r_state;
      ready_out   = 1'b0;
      valid_out   = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_out = 1'b1;
            if (valid_in) w_stateNext = S_ITER;
         end
         S_ITER: begin
`ifdef CORDIC_GAIN_COMP_EN
            if (w_last) w_stateNext = S_GAIN;
`else
            if (w_last) w_stateNext = S_DONE;
`endif
         end
         S_GAIN: w_stateNext = S_DONE;
         S_DONE: begin
            valid_out = 1'b1;
            if (ready_in) w_stateNext = S_IDLE;
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Datapath: capture on accept, iterate, load result registers on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_theta <= '0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_xOut  <= '0;
         r_yOut  <= '0;
         r_thOut <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid_in) begin
                  r_x     <= w_xFold;
                  r_y     <= w_yFold;
                  r_theta <= w_thFold;
                  r_mode  <= mode_i;
                  r_cnt   <= '0;
               end
            end
            S_ITER: begin
               r_x     <= w_xNext;
               r_y     <= w_yNext;
               r_theta <= w_thNext;
               r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
               if (w_last) begin
                  r_xOut  <= satXY(w_xNext);
                  r_yOut  <= satXY(w_yNext);
                  r_thOut <= satTh(w_thNext);
               end
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_GAIN: begin
               r_xOut  <= satXY(w_xGain);
               r_yOut  <= satXY(w_yGain);
               r_thOut <= satTh(r_theta);
            end
`endif
            default: ;
         endcase
      end
   end

   assign x_o     = r_xOut;
   assign y_o     = r_yOut;
   assign theta_o = r_thOut;

endmodule
`default_nettype wire

// File: tb/tb_cordic_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_engine
//  Purpose  : Self-checking bench for cordic_engine (default and 12-bit
//             instances). Expected values come from ideal floating-point
//             trigonometry scaled by the core gain, with tolerances covering
//             shift truncation and angle-table rounding.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_engine;

   localparam int ITERS = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT  = ITERS + EXTRA;
   localparam int LATS = 12 + EXTRA;

   typedef struct packed {
      logic mode;
      int   x;
      int   y;
      int   th;
      int   ex;
      int   ey;
      int   eth;
      int   tolXY;
      int   tolTh;
   } vecT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, mode_i, valid_in, ready_in, ready_out, valid_out;
   logic [16:0] x_i, y_i, theta_i, x_o, y_o, theta_o;
   logic        sMode, sValidIn, sReadyIn, sReadyOut, sValidOut;
   logic [12:0] sX_i, sY_i, sX_o, sY_o;
   logic [16:0] sTheta_i, sTheta_o;

   cordic_engine #(.XY_BITS(16), .THETA_BITS(16), .ANG_FRAC(8), .ITERATIONS(16), .GUARD_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .valid_in(valid_in), .ready_out(ready_out),
      .x_i(x_i), .y_i(y_i), .theta_i(theta_i), .valid_out(valid_out), .ready_in(ready_in),
      .x_o(x_o), .y_o(y_o), .theta_o(theta_o));

   cordic_engine #(.XY_BITS(12), .THETA_BITS(16), .ANG_FRAC(8), .ITERATIONS(12), .GUARD_BITS(2)) dutS (
      .clk(clk), .rst_n(rst_n), .mode_i(sMode), .valid_in(sValidIn), .ready_out(sReadyOut),
      .x_i(sX_i), .y_i(sY_i), .theta_i(sTheta_i), .valid_out(sValidOut), .ready_in(sReadyIn),
      .x_o(sX_o), .y_o(sY_o), .theta_o(sTheta_o));

   int  errors = 0;
   int  checks = 0;
   vecT sb[$];
   vecT tab[11];

   function automatic int rnd(input real v);
      return $rtoi($floor(v + 0.5));
   endfunction

   function automatic real gainOf(input int xyBits, input int iters);
      real k = 1.0;
      for (int i = 0; i < iters; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
      return k * $floor((2.0 ** (xyBits - 1)) / k + 0.5) / (2.0 ** (xyBits - 1));
`else
      return k;
`endif
   endfunction

   function automatic real satR(input real v, input int xyBits);
      real lim = 2.0 ** xyBits - 1.0;
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   // Ideal result of one operation
   function automatic vecT mkVec(input logic mode, input int x, input int y, input int th,
                                 input int xyBits, input int iters, input int tolXY, input int tolTh);
      vecT v;
      real g = gainOf(xyBits, iters);
      real pi = 3.14159265358979;
      real a;
      v.mode = mode; v.x = x; v.y = y; v.th = th;
      v.tolXY = tolXY; v.tolTh = tolTh;
      if (!mode) begin
         a = th / 256.0 * pi / 180.0;
         v.ex  = rnd(satR(g * (x * $cos(a) - y * $sin(a)), xyBits));
         v.ey  = rnd(satR(g * (y * $cos(a) + x * $sin(a)), xyBits));
         v.eth = 0;
      end else begin
         v.ex  = rnd(satR(g * $sqrt(1.0 * x * x + 1.0 * y * y), xyBits));
         v.ey  = 0;
         v.eth = rnd($atan2(1.0 * y, 1.0 * x) * 180.0 / pi * 256.0) + ((x < 0) ? 0 : th);
      end
      return v;
   endfunction

   task automatic checkNear(input string name, input int act, input int exp, input int tol);
      int d = act - exp;
      if (d < 0) d = -d;
      checks++;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic checkEq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one operation on the main instance; optionally hold off the result
   task automatic runOp(input vecT v, input string tag, input int bpCycles);
      int  n;
      vecT e;
      int  hx, hy, ht;
      @(negedge clk);
      mode_i = v.mode; x_i = 17'(v.x); y_i = 17'(v.y); theta_i = 17'(v.th);
      valid_in = 1'b1;
      n = 0;
      while (!ready_out && n < 50) begin @(negedge clk); n++; end
      checkEq({tag, " ready_out before accept"}, int'(ready_out), 1);
      @(posedge clk);
      sb.push_back(v);
      #1 valid_in = 1'b0;
      n = 0;
      while (!valid_out && n < 100) begin @(posedge clk); #1; n++; end
      checkEq({tag, " latency"}, n, LAT);
      e = sb.pop_front();
      checkNear({tag, " x_o"}, $signed(x_o), e.ex, e.tolXY);
      checkNear({tag, " y_o"}, $signed(y_o), e.ey, e.tolXY);
      checkNear({tag, " theta_o"}, $signed(theta_o), e.eth, e.tolTh);
      hx = $signed(x_o); hy = $signed(y_o); ht = $signed(theta_o);
      for (int k = 0; k < bpCycles; k++) begin
         @(negedge clk);
         valid_in = k[0];
         x_i = 17'(1234 + k); y_i = 17'(-777); theta_i = 17'(5000); mode_i = ~mode_i;
         @(posedge clk); #1;
         checkEq($sformatf("%s hold%0d x_o", tag, k), $signed(x_o), hx);
         checkEq($sformatf("%s hold%0d y_o", tag, k), $signed(y_o), hy);
         checkEq($sformatf("%s hold%0d theta_o", tag, k), $signed(theta_o), ht);
         checkEq($sformatf("%s hold%0d valid_out", tag, k), int'(valid_out), 1);
         checkEq($sformatf("%s hold%0d ready_out", tag, k), int'(ready_out), 0);
      end
      @(negedge clk);
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(posedge clk);
      #1 ready_in = 1'b0;
      checkEq({tag, " valid_out after consume"}, int'(valid_out), 0);
      checkEq({tag, " ready_out after consume"}, int'(ready_out), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecT v;
      int  n;
      rst_n = 1'b0; mode_i = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
      x_i = '0; y_i = '0; theta_i = '0;
      sMode = 1'b0; sValidIn = 1'b0; sReadyIn = 1'b0; sX_i = '0; sY_i = '0; sTheta_i = '0;

      // Tolerances cover floor-biased shifts and rounded angle-table entries
      tab[0]  = mkVec(1'b0, 19899,      0,   7680, 16, 16, 8, 4);  //  30 deg
      tab[1]  = mkVec(1'b0, 19899,      0,  38400, 16, 16, 8, 4);  // 150 deg fold
      tab[2]  = mkVec(1'b0, 19899,      0, -46080, 16, 16, 8, 4);  // -180 deg fold
      tab[3]  = mkVec(1'b1, 16384,  16384,      0, 16, 16, 8, 5);  // 45 deg
      tab[4]  = mkVec(1'b1, -16384, 16384,      0, 16, 16, 8, 5);  // 135 deg
      tab[5]  = mkVec(1'b0, 19899,      0,  23040, 16, 16, 8, 4);  // +90 no fold
      tab[6]  = mkVec(1'b0, 19899,      0, -23040, 16, 16, 8, 4);  // -90 no fold
      tab[7]  = mkVec(1'b1, 10000,  -5000,      0, 16, 16, 8, 5);
      tab[8]  = mkVec(1'b0, 10000,   8000,  46080, 16, 16, 8, 4);  // +180 fold
      tab[9]  = mkVec(1'b1, -12000, -9000,      0, 16, 16, 8, 5);  // -180 seed
      tab[10] = mkVec(1'b1, 40000,  40000,      0, 16, 16, 8, 5);  // saturates w/o comp

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkEq("reset ready_out", int'(ready_out), 1);
      checkEq("reset valid_out", int'(valid_out), 0);
      checkEq("reset x_o", $signed(x_o), 0);
      checkEq("reset y_o", $signed(y_o), 0);
      checkEq("reset theta_o", $signed(theta_o), 0);

      for (int i = 0; i < 11; i++) runOp(tab[i], $sformatf("vec%0d", i), 0);

      runOp(tab[0], "backpressure", 5);

      // Reset asynchronously in the middle of iteration 7
      @(negedge clk);
      mode_i = 1'b0; x_i = 17'(19899); y_i = '0; theta_i = 17'(7680); valid_in = 1'b1;
      @(posedge clk);
      sb.push_back(tab[0]);
      #1 valid_in = 1'b0;
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      checkEq("midreset valid_out", int'(valid_out), 0);
      checkEq("midreset ready_out", int'(ready_out), 1);
      checkEq("midreset x_o", $signed(x_o), 0);
      checkEq("midreset y_o", $signed(y_o), 0);
      checkEq("midreset theta_o", $signed(theta_o), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkEq("postreset ready_out", int'(ready_out), 1);
      checkEq("postreset valid_out", int'(valid_out), 0);
      runOp(tab[3], "afterreset", 0);
      checkEq("scoreboard empty", sb.size(), 0);

      // 12-bit, 12-iteration instance at 45 degrees
      v = mkVec(1'b0, 1244, 0, 11520, 12, 12, 4, 8);
      @(negedge clk);
      sMode = 1'b0; sX_i = 13'(v.x); sY_i = '0; sTheta_i = 17'(v.th); sValidIn = 1'b1;
      n = 0;
      while (!sReadyOut && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      sb.push_back(v);
      #1 sValidIn = 1'b0;
      n = 0;
      while (!sValidOut && n < 100) begin @(posedge clk); #1; n++; end
      checkEq("small latency", n, LATS);
      v = sb.pop_front();
      checkNear("small x_o", $signed(sX_o), v.ex, v.tolXY);
      checkNear("small y_o", $signed(sY_o), v.ey, v.tolXY);
      checkNear("small theta_o", $signed(sTheta_o), v.eth, v.tolTh);
      @(negedge clk);
      sReadyIn = 1'b1;
      @(posedge clk);
      #1 sReadyIn = 1'b0;
      checkEq("small valid_out after consume", int'(sValidOut), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
